// File: rtl/conv_layer_sequencer_if.sv
// rtl/conv_layer_sequencer_if.sv - control, bias and datapath-valid signals of the conv layer sequencer
interface conv_layer_sequencer_if #(
    parameter int OC_W  = 9,
    parameter int PIX_W = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             bias_load;
    logic [OC_W-1:0]  bias_addr;
    logic             bias_ack;
    logic             valid_in_bias;
    logic [PIX_W-1:0] pix_addr;
    logic [OC_W-1:0]  oc_idx;
    logic             valid_out;
    logic             out_pop;
    logic             err;

    // master is the surrounding layer logic and datapath; slave is the sequencer
    modport master (
        output start, bias_ack, valid_out, out_pop,
        input  busy, done, bias_load, bias_addr, valid_in_bias, pix_addr, oc_idx, err
    );

    modport slave (
        input  start, bias_ack, valid_out, out_pop,
        output busy, done, bias_load, bias_addr, valid_in_bias, pix_addr, oc_idx, err
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - per-channel bias load, credit-throttled pixel issue and drain for one conv layer
module conv_layer_sequencer #(
    parameter int NUM_OC  = 512,
    parameter int NUM_PIX = 196,
    parameter int CREDITS = 8,
    parameter int OC_W    = $clog2(NUM_OC),
    parameter int PIX_W   = $clog2(NUM_PIX + 1),
    parameter int CR_W    = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_layer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BIAS,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [OC_W-1:0]  oc, oc_next;
    logic [PIX_W-1:0] issue_cnt, issue_cnt_next;
    logic [PIX_W-1:0] ret_cnt, ret_cnt_next;
    logic [CR_W-1:0]  outstanding, outstanding_next;

    logic busy_q, busy_next;
    logic done_q, done_next;
    logic bias_load_q, bias_load_next;
    logic valid_q, valid_next;
    logic err_q, err_next;

    logic issue;
    logic pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            oc          <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bias_load_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_next;
            oc          <= oc_next;
            issue_cnt   <= issue_cnt_next;
            ret_cnt     <= ret_cnt_next;
            outstanding <= outstanding_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
            bias_load_q <= bias_load_next;
            valid_q     <= valid_next;
            err_q       <= err_next;
        end
    end

    always_comb begin
        state_next       = state;
        oc_next          = oc;
        issue_cnt_next   = issue_cnt;
        ret_cnt_next     = ret_cnt;
        outstanding_next = outstanding;
        err_next         = err_q;

        // valid_q is only ever high in RUN with a free credit, so it is the issue strobe
        issue  = valid_q;
        pop_ok = bus.out_pop && (outstanding != '0);

        if (bus.out_pop && (outstanding == '0)) begin
            err_next = 1'b1;
        end

        // Results are only legal while this channel still expects some
        if (bus.valid_out) begin
            if (((state == S_RUN) || (state == S_DRAIN)) && (ret_cnt != PIX_W'(NUM_PIX))) begin
                ret_cnt_next = ret_cnt + 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end

        if (issue && !pop_ok) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!issue && pop_ok) begin
            outstanding_next = outstanding - 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next     = S_LOAD_BIAS;
                    oc_next        = '0;
                    issue_cnt_next = '0;
                    ret_cnt_next   = '0;
                end
            end
            S_LOAD_BIAS: begin
                if (bus.bias_ack) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    issue_cnt_next = issue_cnt + 1'b1;
                    if (issue_cnt == PIX_W'(NUM_PIX - 1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Bias may only change once every in-flight result of this channel is back
                if (ret_cnt == PIX_W'(NUM_PIX)) begin
                    if (oc == OC_W'(NUM_OC - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        state_next     = S_LOAD_BIAS;
                        oc_next        = oc + 1'b1;
                        issue_cnt_next = '0;
                        ret_cnt_next   = '0;
                    end
                end
            end
            S_DONE: begin
                state_next     = S_IDLE;
                oc_next        = '0;
                issue_cnt_next = '0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with the state they describe
        busy_next      = (state_next != S_IDLE);
        done_next      = (state_next == S_DONE);
        bias_load_next = (state_next == S_LOAD_BIAS);
        valid_next     = (state_next == S_RUN) && (outstanding_next < CR_W'(CREDITS));
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.bias_load     = bias_load_q;
    assign bus.bias_addr     = oc;
    assign bus.valid_in_bias = valid_q;
    assign bus.pix_addr      = issue_cnt;
    assign bus.oc_idx        = oc;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - directed scoreboard bench for conv_layer_sequencer
module tb_conv_layer_sequencer;

    localparam int NUM_OC   = 2;
    localparam int NUM_PIX  = 4;
    localparam int PIPE_LAT = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    conv_layer_sequencer_if #(.OC_W(1), .PIX_W(3)) bus ();
    conv_layer_sequencer_if #(.OC_W(1), .PIX_W(3)) bus2 ();

    conv_layer_sequencer #(.NUM_OC(NUM_OC), .NUM_PIX(NUM_PIX), .CREDITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_layer_sequencer #(.NUM_OC(NUM_OC), .NUM_PIX(NUM_PIX), .CREDITS(2)) dut_c2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [PIPE_LAT-1:0] hist = '0;
    logic vo_prev  = 1'b0;
    logic bl_prev  = 1'b0;
    logic ack_prev = 1'b0;
    bit   pop_en = 1'b1;
    bit   force_pop = 1'b0;
    bit   inj_pending = 1'b0;
    int   n_vo, n_issue, n_done;
    int   mo2 = 0;
    int   mo2_max = 0;
    int   sb_q[$];
    int   bias_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: account dut_c2 credits, advance the datapath model, then monitor this cycle
    task automatic tick();
        logic vo_real;
        int   e;
        if (rst2) begin
            mo2 = 0;
        end else begin
            if (bus2.out_pop && mo2 > 0) mo2 = mo2 - 1 + int'(bus2.valid_in_bias);
            else mo2 = mo2 + int'(bus2.valid_in_bias);
        end
        if (mo2 > mo2_max) mo2_max = mo2;

        @(posedge clk);
        #1;
        vo_real = hist[PIPE_LAT-1];
        bus.valid_out = vo_real;
        if (!vo_real && inj_pending && n_vo == NUM_PIX) begin
            bus.valid_out = 1'b1;
            inj_pending = 1'b0;
        end
        bus.out_pop  = (pop_en && vo_prev) || force_pop;
        bus.bias_ack = bl_prev && !ack_prev;
        if (vo_real) n_vo++;

        if (bus.valid_in_bias) begin
            n_issue++;
            if (sb_q.size() == 0) begin
                check("unexpected_issue", 32'(bus.pix_addr), 32'hffff_ffff);
            end else begin
                e = sb_q.pop_front();
                check("issue_oc_pix", 32'({bus.oc_idx, bus.pix_addr}), 32'(e));
            end
        end
        if (bus.bias_load && !bl_prev) begin
            if (bias_q.size() == 0) begin
                check("unexpected_bias_load", 32'(bus.bias_addr), 32'hffff_ffff);
            end else begin
                e = bias_q.pop_front();
                check("bias_addr", 32'(bus.bias_addr), 32'(e));
                check("bias_after_drain", 32'(n_vo), 32'(NUM_PIX * e));
            end
        end
        if (bus.done) n_done++;

        ack_prev = bus.bias_ack;
        bl_prev  = bus.bias_load;
        vo_prev  = vo_real;
        hist     = {hist[PIPE_LAT-2:0], bus.valid_in_bias};
        if (rst) begin
            hist     = '0;
            vo_prev  = 1'b0;
            bl_prev  = 1'b0;
            ack_prev = 1'b0;
        end
    endtask

    task automatic load_expect();
        sb_q.delete();
        bias_q.delete();
        for (int oc = 0; oc < NUM_OC; oc++) begin
            bias_q.push_back(oc);
            for (int p = 0; p < NUM_PIX; p++) sb_q.push_back(oc * 8 + p);
        end
        n_vo = 0;
        n_issue = 0;
        n_done = 0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, 32'(bus.busy), 0);
        check({pfx, "_done"}, 32'(bus.done), 0);
        check({pfx, "_bias_load"}, 32'(bus.bias_load), 0);
        check({pfx, "_valid_in_bias"}, 32'(bus.valid_in_bias), 0);
        check({pfx, "_err"}, 32'(bus.err), 0);
        check({pfx, "_bias_addr"}, 32'(bus.bias_addr), 0);
        check({pfx, "_pix_addr"}, 32'(bus.pix_addr), 0);
        check({pfx, "_oc_idx"}, 32'(bus.oc_idx), 0);
    endtask

    task automatic run_layer(input string pfx, input bit start_mid);
        bit pulse_mid;
        pulse_mid = start_mid;
        load_expect();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({pfx, "_start_bias_load"}, 32'(bus.bias_load), 1);
        check({pfx, "_start_busy"}, 32'(bus.busy), 1);
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            if (pulse_mid && n_issue == 1) begin
                bus.start = 1'b1;
                pulse_mid = 1'b0;
            end
            tick();
            bus.start = 1'b0;
        end
        check({pfx, "_done_seen"}, 32'(n_done), 1);
        check({pfx, "_issues"}, 32'(n_issue), 8);
        check({pfx, "_sb_empty"}, 32'(sb_q.size()), 0);
        check({pfx, "_bias_q_empty"}, 32'(bias_q.size()), 0);
        tick();
        check({pfx, "_done_width"}, 32'(bus.done), 0);
        check({pfx, "_busy_after_done"}, 32'(bus.busy), 0);
        for (int i = 0; i < 6; i++) tick();
        check({pfx, "_single_done"}, 32'(n_done), 1);
        check({pfx, "_stays_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int n2;
        bus.start = 0; bus.bias_ack = 0; bus.valid_out = 0; bus.out_pop = 0;
        bus2.start = 0; bus2.bias_ack = 0; bus2.valid_out = 0; bus2.out_pop = 0;
        load_expect();

        repeat (3) tick();
        check_zero("reset");
        check("reset_c2_busy", 32'(bus2.busy), 0);
        check("reset_c2_valid", 32'(bus2.valid_in_bias), 0);
        rst = 1'b0;
        rst2 = 1'b0;
        tick();

        // Full two-channel layer with auto-popping downstream
        run_layer("t1", 1'b0);
        check("t1_err", 32'(bus.err), 0);

        // Credit limit of 2 with no pops: two issues, then one pop frees one more
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("t2_bias_load", 32'(bus2.bias_load), 1);
        bus2.bias_ack = 1'b1;
        tick();
        bus2.bias_ack = 1'b0;
        n2 = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus2.valid_in_bias) n2++;
            tick();
        end
        check("t2_issues_before_stall", 32'(n2), 2);
        check("t2_stalled", 32'(bus2.valid_in_bias), 0);
        bus2.out_pop = 1'b1;
        tick();
        bus2.out_pop = 1'b0;
        check("t2_resume_valid", 32'(bus2.valid_in_bias), 1);
        check("t2_resume_pix", 32'(bus2.pix_addr), 2);
        tick();
        check("t2_stall_again", 32'(bus2.valid_in_bias), 0);

        // Issue and pop together at CREDITS-1 keeps the count, so one more issue fits
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("t6_reset_busy", 32'(bus2.busy), 0);
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.bias_ack = 1'b1;
        tick();
        bus2.bias_ack = 1'b0;
        check("t6_issue0", 32'({bus2.valid_in_bias, bus2.pix_addr}), 32'h8);
        tick();
        check("t6_issue1", 32'({bus2.valid_in_bias, bus2.pix_addr}), 32'h9);
        bus2.out_pop = 1'b1;
        tick();
        bus2.out_pop = 1'b0;
        check("t6_issue2", 32'({bus2.valid_in_bias, bus2.pix_addr}), 32'ha);
        tick();
        check("t6_stall", 32'(bus2.valid_in_bias), 0);
        check("t6_err", 32'(bus2.err), 0);
        check("c2_outstanding_max", 32'(mo2_max), 2);
        rst2 = 1'b1;

        // start pulsed again mid-RUN is ignored
        run_layer("t4", 1'b1);
        check("t4_err", 32'(bus.err), 0);

        // Reset in RUN after two issues, then a clean full layer
        load_expect();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && n_issue < 2; i++) tick();
        check("t5_two_issues", 32'(n_issue), 2);
        check("t5_pix_before_rst", 32'(bus.pix_addr), 1);
        rst = 1'b1;
        tick();
        check_zero("t5_after_rst");
        rst = 1'b0;
        run_layer("t5", 1'b0);
        check("t5_err", 32'(bus.err), 0);

        // Extra valid_out after a channel's last result flags err but does not derail the layer
        inj_pending = 1'b1;
        run_layer("t3b", 1'b0);
        check("t3b_err", 32'(bus.err), 1);

        // Pop with nothing outstanding: err sticks, credits stay intact for the next layer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3a_err_cleared", 32'(bus.err), 0);
        force_pop = 1'b1;
        tick();
        force_pop = 1'b0;
        tick();
        check("t3a_err_set", 32'(bus.err), 1);
        run_layer("t3a", 1'b0);
        check("t3a_err_sticky", 32'(bus.err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
